online_ccm_test_ctrl: RTL and testbench
=======================================

Name: online_ccm_test_ctrl

Overview:
- Sequencer for one overclocked online constant-coefficient multiplier (CCM) under test, e.g. the ×203 CCM.
- Accepts operand/golden-result pairs over a valid/ready handshake and launches the operand onto the CCM input register.
- Waits a programmable number of cycles, then captures the CCM output and compares it with the golden value.
- Returns the captured result with a mismatch flag and keeps saturating run/error statistics for the overclocking sweep.

Parameters:
- STAGE, 4, CCM operand digit count; operand width WL = 2*STAGE bits (2 bits per redundant digit).
- WL_OUT, 26, CCM result width (2*(STAGE+9) for the ×203 CCM).
- WAIT_W, 8, width of the settle-wait counter.
- STAT_W, 16, width of the run and error counters.

Ports:
- clk  in  1  single clock for all state.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  controller can accept a pair (IDLE only).
- in_x  in  WL  operand in redundant format.
- in_exp  in  WL_OUT  golden CCM result, bit-exact redundant encoding.
- cfg_wait  in  WAIT_W  extra settle cycles before capture; sampled at accept.
- abort  in  1  cancel the current launch.
- clr_stats  in  1  synchronous clear of run_cnt and err_cnt.
- dp_x  out  WL  registered operand driven into the CCM.
- dp_y  in  WL_OUT  CCM combinational result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_y  out  WL_OUT  captured CCM result.
- out_err  out  1  out_y != golden.
- run_cnt  out  STAT_W  completed (accepted) results, saturating.
- err_cnt  out  STAT_W  mismatching completed results, saturating.

Behaviour:
- Reset (async, rst_n=0): state IDLE; dp_x, out_y, out_err, run_cnt, err_cnt = 0; out_valid = 0; in_ready = 0 while rst_n is low. Reset mid-operation discards the operation; no output is produced for it.
- States:
  - IDLE: in_ready=1. On an edge with in_valid=1: dp_x<=in_x, exp_q<=in_exp, wcnt<=cfg_wait, go to WAIT.
  - WAIT: in_ready=0. Edge with abort=1: go to IDLE; dp_x holds; no counters change. Else if wcnt!=0: wcnt<=wcnt-1. Else (wcnt==0): out_y<=dp_y, out_err<=(dp_y!=exp_q), go to DONE.
  - DONE: out_valid=1; out_y and out_err stable. abort is ignored. On an edge with out_ready=1: run_cnt+1, err_cnt+out_err (both saturate at all-ones), go to IDLE.
- Timing: accept at edge T0. Capture at edge T0+cfg_wait+1. out_valid is high from T0+cfg_wait+1 until the handshake. cfg_wait=0 gives exactly one cycle of CCM settle (the register-to-register path under test).
- Throughput: in_ready is low in DONE, so there is at least one idle cycle between results. Minimum period is cfg_wait+3 cycles with out_ready held high.
- clr_stats: takes priority over an increment in the same cycle (counters become 0). It does not affect the FSM.
- cfg_wait changes after accept have no effect on the operation in flight.
- dp_x changes only at accept, so the CCM input is stable through WAIT.
- Comparison is bit-exact on the redundant encoding; no conversion to non-redundant form.

Decomposition:
- Shared package (ccm_test_pkg):
  - State enum {IDLE, WAIT, DONE}.
  - WL/WL_OUT derivation functions from STAGE and the CCM shift constants.
  - Default STAT_W and WAIT_W.
- One natural sub-module: sat_counter (width parameter, inc, clr, async active-low reset). Instantiate it for run_cnt and err_cnt.

Test Plan:
- Reset/idle: rst_n low for 3 cycles → out_valid=0, in_ready=0, counters 0; after release in_ready=1, dp_x=0.
- Latency: in_x=8'h5A, cfg_wait=3, stub drives dp_y=in_exp=26'h0ABCDE once dp_x updates → capture at accept+4, out_valid rises then, out_err=0; after out_ready, run_cnt=1, err_cnt=0.
- Mismatch and stall: stub returns dp_y=exp^1, out_ready held low 10 cycles → out_valid, out_y and out_err=1 held stable; on release err_cnt=1, run_cnt=1.
- Abort: accept, then abort=1 on the 2nd WAIT cycle with cfg_wait=5 → returns to IDLE, no out_valid, run_cnt unchanged, next accept proceeds normally.
- Saturation/clear: preload via 65535 runs with STAT_W=16, all mismatches → err_cnt and run_cnt stop at 16'hFFFF; clr_stats with a concurrent handshake → both 0.
- Async reset mid-WAIT: rst_n pulse between edges → out_y, dp_x and counters immediately 0, state IDLE, no output for the lost operation.

Source files
------------

// File: rtl/ccm_test_pkg.sv
// Shared types and width helpers for the online CCM test controller.
package ccm_test_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // The x203 CCM grows the result by 9 redundant digits over the operand.
  localparam int CCM203_SHIFT = 9;
  localparam int DEF_STAT_W   = 16;
  localparam int DEF_WAIT_W   = 8;

  function automatic int wl_of(input int stage);
    return 2 * stage;
  endfunction

  function automatic int wl_out_of(input int stage, input int shift);
    return 2 * (stage + shift);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_q <= '0;
    else if (clr)                 r_q <= '0;
    else if (inc && (r_q != '1))  r_q <= r_q + 1'b1;
  end

  assign q = r_q;

endmodule

// File: rtl/online_ccm_test_ctrl.sv
// Launches operands into an overclocked online CCM, captures after a programmable
// settle time, compares with the golden result and keeps run/error statistics.
module online_ccm_test_ctrl import ccm_test_pkg::*; #(
  parameter int STAGE  = 4,
  parameter int WL_OUT = wl_out_of(STAGE, CCM203_SHIFT),
  parameter int WAIT_W = DEF_WAIT_W,
  parameter int STAT_W = DEF_STAT_W,
  localparam int WL    = wl_of(STAGE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WL-1:0]     in_x,
  input  logic [WL_OUT-1:0] in_exp,
  input  logic [WAIT_W-1:0] cfg_wait,
  input  logic              abort,
  input  logic              clr_stats,
  output logic [WL-1:0]     dp_x,
  input  logic [WL_OUT-1:0] dp_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WL_OUT-1:0] out_y,
  output logic              out_err,
  output logic [STAT_W-1:0] run_cnt,
  output logic [STAT_W-1:0] err_cnt
);

  state_e            r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_out_err;
  logic [WL-1:0]     r_dp_x;
  logic [WL_OUT-1:0] r_exp;
  logic [WL_OUT-1:0] r_out_y;
  logic [WAIT_W-1:0] r_wcnt;
  logic              w_hs;

  assign w_hs = (r_state == S_DONE) && out_ready;

  // in_ready is registered so it stays low for the whole reset assertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
      r_dp_x      <= '0;
      r_exp       <= '0;
      r_out_y     <= '0;
      r_wcnt      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_dp_x     <= in_x;
            r_exp      <= in_exp;
            r_wcnt     <= cfg_wait;
            r_in_ready <= 1'b0;
            r_state    <= S_WAIT;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (abort) begin
            r_in_ready <= 1'b1;
            r_state    <= S_IDLE;
          end else if (r_wcnt != '0) begin
            r_wcnt <= r_wcnt - 1'b1;
          end else begin
            r_out_y     <= dp_y;
            r_out_err   <= (dp_y != r_exp);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_in_ready <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  sat_counter #(.W(STAT_W)) u_run_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_hs),
    .clr   (clr_stats),
    .q     (run_cnt)
  );

  sat_counter #(.W(STAT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_hs && r_out_err),
    .clr   (clr_stats),
    .q     (err_cnt)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;
  assign out_err   = r_out_err;
  assign dp_x      = r_dp_x;

endmodule

// File: tb/tb_online_ccm_test_ctrl.sv
// Table-driven bench with a result scoreboard plus hand sequences for abort,
// saturation/clear and asynchronous reset.
module tb_online_ccm_test_ctrl;
  localparam int STAGE  = 4;
  localparam int WL     = 2 * STAGE;
  localparam int WL_OUT = 26;
  localparam int WAIT_W = 8;
  localparam int STAT_W = 6;
  localparam int SAT    = (1 << STAT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0, in_ready;
  logic [WL-1:0]     in_x = '0;
  logic [WL_OUT-1:0] in_exp = '0;
  logic [WAIT_W-1:0] cfg_wait = '0;
  logic              abort = 1'b0, clr_stats = 1'b0;
  logic [WL-1:0]     dp_x;
  logic [WL_OUT-1:0] dp_y = '0;
  logic              out_valid, out_ready = 1'b0;
  logic [WL_OUT-1:0] out_y;
  logic              out_err;
  logic [STAT_W-1:0] run_cnt, err_cnt;

  online_ccm_test_ctrl #(.STAGE(STAGE), .WL_OUT(WL_OUT), .WAIT_W(WAIT_W), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .in_exp(in_exp), .cfg_wait(cfg_wait), .abort(abort), .clr_stats(clr_stats),
    .dp_x(dp_x), .dp_y(dp_y), .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_err(out_err), .run_cnt(run_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WL-1:0]     x;
    logic [WL_OUT-1:0] exp_v;
    logic [WL_OUT-1:0] y;
    logic [WAIT_W-1:0] w;
    int                hold;
  } vec_t;

  typedef struct {
    logic [WL_OUT-1:0] y;
    logic              err;
  } res_t;

  res_t sb[$];
  vec_t tbl[6];
  int   checks = 0, errors = 0;
  int   m_run = 0, m_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic count_hs(input logic err);
    m_run = (m_run < SAT) ? m_run + 1 : SAT;
    if (err) m_err = (m_err < SAT) ? m_err + 1 : SAT;
  endtask

  // Accept one pair, check latency, hold the result, then hand it off.
  task automatic run_op(input vec_t v, input bit full);
    res_t e;
    int   lat;
    @(negedge clk);
    if (full) chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_x = v.x; in_exp = v.exp_v; cfg_wait = v.w;
    sb.push_back('{v.y, (v.y != v.exp_v)});
    @(posedge clk); #1;
    in_valid = 1'b0; dp_y = v.y; cfg_wait = ~v.w;
    if (full) chk("dp_x_launch", dp_x, v.x);
    lat = 0;
    while (!out_valid && lat < 400) begin @(posedge clk); #1; lat++; end
    if (full) chk("latency", lat, v.w + 1);
    e = sb.pop_front();
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk); #1;
      chk("stall_stable", {out_valid, out_err, out_y}, {1'b1, e.err, e.y});
    end
    if (full) begin
      chk("out_y", out_y, e.y);
      chk("out_err", out_err, e.err);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    count_hs(e.err);
    if (full) begin
      chk("run_cnt", run_cnt, m_run);
      chk("err_cnt", err_cnt, m_err);
      chk("out_valid_drop", out_valid, 0);
    end
  endtask

  initial begin
    tbl[0] = '{8'h5A, 26'h0ABCDE, 26'h0ABCDE, 8'd3, 0};
    tbl[1] = '{8'hC3, 26'h1234567, 26'h1234566, 8'd2, 10};
    tbl[2] = '{8'h01, 26'h3FFFFFF, 26'h3FFFFFF, 8'd0, 0};
    tbl[3] = '{8'hFF, 26'h2000000, 26'h0000000, 8'd0, 2};
    tbl[4] = '{8'h77, 26'h155AA55, 26'h155AA55, 8'd255, 1};
    tbl[5] = '{8'h80, 26'h0F0F0F0, 26'h0F0F0F1, 8'd7, 0};

    // Reset held for 3 cycles
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_run_cnt", run_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_dp_x", dp_x, 0);

    foreach (tbl[i]) run_op(tbl[i], 1'b1);

    // Abort on the 2nd WAIT cycle
    @(negedge clk);
    in_valid = 1'b1; in_x = 8'h3C; in_exp = 26'h1; cfg_wait = 8'd5;
    @(posedge clk); #1; in_valid = 1'b0; dp_y = 26'h1;
    @(negedge clk); abort = 1'b1;
    @(posedge clk); @(negedge clk); abort = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", out_valid, 0);
    end
    chk("abort_in_ready", in_ready, 1);
    chk("abort_dp_x_hold", dp_x, 8'h3C);
    chk("abort_run_cnt", run_cnt, m_run);
    chk("abort_err_cnt", err_cnt, m_err);
    run_op('{8'h42, 26'h0000042, 26'h0000042, 8'd1, 0}, 1'b1);

    // Drive both counters into saturation with mismatching results
    for (int i = 0; i < SAT + 2; i++)
      run_op('{WL'(i), 26'h0000010, 26'h0000011, 8'd0, 0}, 1'b0);
    chk("sat_run_cnt", run_cnt, SAT);
    chk("sat_err_cnt", err_cnt, SAT);

    // Abort ignored in DONE; clear wins over a concurrent handshake
    @(negedge clk);
    in_valid = 1'b1; in_x = 8'h99; in_exp = 26'h5; cfg_wait = 8'd0;
    @(posedge clk); #1; in_valid = 1'b0; dp_y = 26'h6;
    @(posedge clk); #1;
    chk("done_valid", out_valid, 1);
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    chk("done_abort_ignored", out_valid, 1);
    @(negedge clk); out_ready = 1'b1; clr_stats = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0; clr_stats = 1'b0;
    m_run = 0; m_err = 0;
    chk("clr_run_cnt", run_cnt, 0);
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_hs_done", out_valid, 0);
    run_op('{8'h12, 26'h0000ABC, 26'h0000ABD, 8'd1, 0}, 1'b1);

    // Async reset pulse mid-WAIT
    @(negedge clk);
    in_valid = 1'b1; in_x = 8'hA5; in_exp = 26'h7; cfg_wait = 8'd10;
    @(posedge clk); #1; in_valid = 1'b0; dp_y = 26'h7;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0; #1;
    chk("arst_out_y", out_y, 0);
    chk("arst_dp_x", dp_x, 0);
    chk("arst_run_cnt", run_cnt, 0);
    chk("arst_err_cnt", err_cnt, 0);
    chk("arst_in_ready", in_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    m_run = 0; m_err = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      chk("arst_no_output", out_valid, 0);
    end
    chk("arst_idle", in_ready, 1);
    run_op('{8'h0F, 26'h00000F0, 26'h00000F0, 8'd2, 0}, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
